spi_slave_sync: RTL and testbench

Parametrised, full-duplex SPI slave running entirely in the system clock domain. It oversamples SCLK, CS_n and MOSI through synchronisers, supports all four CPOL/CPHA modes, configurable word width and bit order, and adds a MISO transmit path with a valid/ready load handshake. It sits between an external SPI master and the on-chip register/command logic, replacing the earlier SCLK-clocked 8-bit receive-only slave.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_sync_edge.sv | 62 ++++++
 rtl/spi_slave_sync.sv | 205 ++++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// spi_pkg : mode encodings, FSM states and helpers for spi_slave_sync
// rev 1.0
// ----------------------------------------------------------------------
package spi_pkg;

  // Mode encodings as {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  function automatic int spi_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------
// spi_sync_edge : multi-stage synchroniser with optional rise/fall detect
// rev 1.0
// ----------------------------------------------------------------------
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0,
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_DETECT) begin : g_edge
      logic prev_q;
      logic prev_d;

      always_comb begin
        prev_d = o_q;
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          prev_q <= RESET_VAL;
        end else begin
          prev_q <= prev_d;
        end
      end

      assign o_rise = o_q & ~prev_q;
      assign o_fall = ~o_q & prev_q;
    end else begin : g_no_edge
      assign o_rise = 1'b0;
      assign o_fall = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/spi_slave_sync.sv
`default_nettype none
// ----------------------------------------------------------------------
// spi_slave_sync : oversampled full-duplex SPI slave, all four modes
// rev 1.0
// ----------------------------------------------------------------------
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cs_n,
  input  logic             i_sclk,
  input  logic             i_mosi,
  output logic             o_miso,
  output logic             o_miso_oe,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid,
  output logic             o_tx_underrun,
  output logic             o_busy
);

  localparam int             CNT_W    = spi_clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL), .EDGE_DETECT(1'b1)) u_sclk_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sclk),
    .o_q(sclk_level), .o_rise(sclk_rise), .o_fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_DETECT(1'b1)) u_cs_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_cs_n),
    .o_q(cs_sync), .o_rise(cs_rise), .o_fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_DETECT(1'b0)) u_mosi_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_mosi),
    .o_q(mosi_sync), .o_rise(mosi_rise), .o_fall(mosi_fall)
  );

  assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall};

  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  function automatic logic tx_head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] tx_advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] rx_insert(input logic [WIDTH-1:0] w, input logic b);
    return MSB_FIRST ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             miso_q, miso_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             word_done_q, word_done_d;
  logic             underrun_q, underrun_d;
  logic             pend_underrun_q, pend_underrun_d;
  logic [WIDTH-1:0] load_word;
  logic             tx_take;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rx_shift_d      = rx_shift_q;
    tx_shift_d      = tx_shift_q;
    hold_d          = hold_q;
    hold_full_d     = hold_full_q;
    miso_d          = miso_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    word_done_d     = 1'b0;
    underrun_d      = 1'b0;
    pend_underrun_d = pend_underrun_q;
    tx_take         = 1'b0;
    load_word       = hold_full_q ? hold_q : '0;

    if (word_done_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end

    if (cs_rise) begin
      state_d         = IDLE;
      cnt_d           = '0;
      rx_shift_d      = '0;
      miso_d          = 1'b0;
      pend_underrun_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) state_d = LOAD;
        end
        LOAD: begin
          tx_take         = 1'b1;
          tx_shift_d      = load_word;
          pend_underrun_d = ~hold_full_q;
          if (!CPHA) miso_d = tx_head(load_word);
          state_d = SHIFT;
        end
        SHIFT: begin
          if (sample_edge) begin
            rx_shift_d = rx_insert(rx_shift_q, mosi_sync);
            // Underrun is reported when an empty-reload word actually begins,
            // so the speculative reload after the last word of a frame stays silent.
            if (cnt_q == '0 && pend_underrun_q) begin
              underrun_d      = 1'b1;
              pend_underrun_d = 1'b0;
            end
            if (cnt_q == LAST_BIT) begin
              cnt_d       = '0;
              word_done_d = 1'b1;
              state_d     = LOAD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (shift_edge) begin
            if (cnt_q == '0) begin
              if (CPHA) miso_d = tx_head(tx_shift_q);
            end else begin
              tx_shift_d = tx_advance(tx_shift_q);
              miso_d     = tx_head(tx_advance(tx_shift_q));
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (i_tx_valid && !hold_full_q) begin
      hold_d      = i_tx_data;
      hold_full_d = 1'b1;
    end else if (tx_take) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      rx_shift_q      <= '0;
      tx_shift_q      <= '0;
      hold_q          <= '0;
      hold_full_q     <= 1'b0;
      miso_q          <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      word_done_q     <= 1'b0;
      underrun_q      <= 1'b0;
      pend_underrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rx_shift_q      <= rx_shift_d;
      tx_shift_q      <= tx_shift_d;
      hold_q          <= hold_d;
      hold_full_q     <= hold_full_d;
      miso_q          <= miso_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      word_done_q     <= word_done_d;
      underrun_q      <= underrun_d;
      pend_underrun_q <= pend_underrun_d;
    end
  end

  assign o_miso        = miso_q & ~cs_sync;
  assign o_miso_oe     = ~cs_sync;
  assign o_busy        = ~cs_sync;
  assign o_tx_ready    = ~hold_full_q;
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_tx_underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_spi_slave_sync : five slave configurations driven by one SPI master
// rev 1.0
// ----------------------------------------------------------------------
module tb_spi_slave_sync;
  import spi_pkg::*;

  localparam int N_DUT = 5;
  localparam int H     = 80;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, mosi;
  logic [15:0] tx_data;
  logic        cs_n     [N_DUT];
  logic        tx_valid [N_DUT];
  logic        miso     [N_DUT];
  logic        miso_oe  [N_DUT];
  logic        tx_ready [N_DUT];
  logic        rx_valid [N_DUT];
  logic        underrun [N_DUT];
  logic        busy     [N_DUT];
  logic [15:0] rx_data  [N_DUT];

  always #5 clk = ~clk;

  // Instances 0..3: WIDTH 8, MSB first, SPI modes 0..3.  Instance 4: WIDTH 16, LSB first, mode 0.
  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int         W    = (g == 4) ? 16 : 8;
    localparam logic [1:0] MODE = (g == 4) ? SPI_MODE0 : 2'(g);
    logic [W-1:0] rxd;

    spi_slave_sync #(
      .WIDTH(W), .CPOL(MODE[1]), .CPHA(MODE[0]), .MSB_FIRST(g != 4), .SYNC_STAGES(2)
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cs_n(cs_n[g]), .i_sclk(sclk), .i_mosi(mosi),
      .o_miso(miso[g]), .o_miso_oe(miso_oe[g]),
      .i_tx_data(tx_data[W-1:0]), .i_tx_valid(tx_valid[g]), .o_tx_ready(tx_ready[g]),
      .o_rx_data(rxd), .o_rx_valid(rx_valid[g]), .o_tx_underrun(underrun[g]), .o_busy(busy[g])
    );

    assign rx_data[g] = 16'(rxd);
  end

  function automatic int cfg_width(input int i);
    return (i == 4) ? 16 : 8;
  endfunction

  function automatic bit cfg_msb(input int i);
    return i != 4;
  endfunction

  function automatic logic [1:0] cfg_mode(input int i);
    case (i)
      1:       return SPI_MODE1;
      2:       return SPI_MODE2;
      3:       return SPI_MODE3;
      default: return SPI_MODE0;
    endcase
  endfunction

  int n_cmp = 0;
  int n_err = 0;
  int urun_cnt [N_DUT];

  typedef struct {
    int          inst;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, req, $time);
    end
  endtask

  // Scoreboard: every rx pulse pops the oldest expected word
  always @(negedge clk) begin
    for (int i = 0; i < N_DUT; i++) begin
      if (underrun[i] === 1'b1) urun_cnt[i]++;
      if (rx_valid[i] === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rx_valid_unexpected", {15'd0, rx_valid[i]}, 16'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rx_instance", 16'(i), 16'(e.inst));
          check("rx_data", rx_data[i], e.data);
        end
      end
    end
  end

  task automatic push_exp(input int inst, input logic [15:0] data);
    exp_t e;
    e.inst = inst;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("rx_valid_timeout", 16'(exp_q.size()), 16'd0);
      exp_q.delete();
    end
  endtask

  task automatic tx_load(input int inst, input logic [15:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!tx_ready[inst] && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_wait", {15'd0, tx_ready[inst]}, 16'd1);
    tx_data        = d;
    tx_valid[inst] = 1'b1;
    @(negedge clk);
    tx_valid[inst] = 1'b0;
    check("tx_ready_drop", {15'd0, tx_ready[inst]}, 16'd0);
  endtask

  task automatic cs_start(input int inst);
    logic [1:0] m;
    m    = cfg_mode(inst);
    sclk = m[1];
    #(H);
    cs_n[inst] = 1'b0;
    #(2 * H);
    check("busy_on", {15'd0, busy[inst]}, 16'd1);
    check("miso_oe_on", {15'd0, miso_oe[inst]}, 16'd1);
  endtask

  task automatic cs_end(input int inst);
    #(H);
    cs_n[inst] = 1'b1;
    #(2 * H);
    check("busy_off", {15'd0, busy[inst]}, 16'd0);
  endtask

  task automatic xfer(input int inst, input logic [15:0] dout, input int nbits,
                      output logic [15:0] din);
    logic [1:0] m;
    int         w, b;
    bit         msb;
    m   = cfg_mode(inst);
    w   = cfg_width(inst);
    msb = cfg_msb(inst);
    din = '0;
    for (int k = 0; k < nbits; k++) begin
      b = msb ? (w - 1 - k) : k;
      if (!m[0]) begin
        mosi = dout[b];
        #(H);
        sclk   = ~m[1];
        din[b] = miso[inst];
        #(H);
        sclk = m[1];
      end else begin
        sclk = ~m[1];
        mosi = dout[b];
        #(H);
        sclk   = m[1];
        din[b] = miso[inst];
        #(H);
      end
    end
  endtask

  task automatic check_reset_state(input int i);
    check("rst_rx_data", rx_data[i], 16'd0);
    check("rst_rx_valid", {15'd0, rx_valid[i]}, 16'd0);
    check("rst_tx_ready", {15'd0, tx_ready[i]}, 16'd1);
    check("rst_underrun", {15'd0, underrun[i]}, 16'd0);
    check("rst_busy", {15'd0, busy[i]}, 16'd0);
    check("rst_miso_oe", {15'd0, miso_oe[i]}, 16'd0);
    check("rst_miso", {15'd0, miso[i]}, 16'd0);
  endtask

  typedef struct {
    int          inst;
    logic [15:0] mosi_word;
    logic [15:0] tx_word;
    logic [15:0] exp_rx;
    logic [15:0] exp_miso;
  } vec_t;
  vec_t vecs [7];

  initial begin
    #(500_000);
    $display("FAIL global_timeout: simulation did not complete (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] din;

    vecs[0] = '{0, 16'h00A5, 16'h003C, 16'h00A5, 16'h003C};
    vecs[1] = '{1, 16'h0081, 16'h007E, 16'h0081, 16'h007E};
    vecs[2] = '{2, 16'h0081, 16'h007E, 16'h0081, 16'h007E};
    vecs[3] = '{3, 16'h0081, 16'h007E, 16'h0081, 16'h007E};
    vecs[4] = '{4, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
    vecs[5] = '{0, 16'h00FF, 16'h0001, 16'h00FF, 16'h0001};
    vecs[6] = '{4, 16'h8001, 16'h00F0, 16'h8001, 16'h00F0};

    rst_n   = 1'b0;
    sclk    = 1'b0;
    mosi    = 1'b0;
    tx_data = '0;
    for (int i = 0; i < N_DUT; i++) begin
      cs_n[i]     = 1'b1;
      tx_valid[i] = 1'b0;
      urun_cnt[i] = 0;
    end
    #(23);
    for (int i = 0; i < N_DUT; i++) check_reset_state(i);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    for (int v = 0; v < 7; v++) begin
      urun_cnt[vecs[v].inst] = 0;
      tx_load(vecs[v].inst, vecs[v].tx_word);
      push_exp(vecs[v].inst, vecs[v].exp_rx);
      cs_start(vecs[v].inst);
      xfer(vecs[v].inst, vecs[v].mosi_word, cfg_width(vecs[v].inst), din);
      cs_end(vecs[v].inst);
      wait_drain();
      check("vec_miso_word", din, vecs[v].exp_miso);
      check("vec_rx_held", rx_data[vecs[v].inst], vecs[v].exp_rx);
      check("vec_no_underrun", 16'(urun_cnt[vecs[v].inst]), 16'd0);
    end

    // Three words under one CS; only two words supplied for transmit
    urun_cnt[0] = 0;
    tx_load(0, 16'h00AA);
    push_exp(0, 16'h0011);
    push_exp(0, 16'h0022);
    push_exp(0, 16'h0033);
    cs_start(0);
    tx_load(0, 16'h00BB);
    xfer(0, 16'h0011, 8, din);
    check("b2b_miso_w1", din, 16'h00AA);
    xfer(0, 16'h0022, 8, din);
    check("b2b_miso_w2", din, 16'h00BB);
    check("b2b_underrun_before_w3", 16'(urun_cnt[0]), 16'd0);
    xfer(0, 16'h0033, 8, din);
    check("b2b_miso_w3", din, 16'h0000);
    cs_end(0);
    wait_drain();
    check("b2b_underrun_count", 16'(urun_cnt[0]), 16'd1);

    // Frame aborted after 5 bits, then a clean frame
    cs_start(0);
    xfer(0, 16'h00F0, 5, din);
    cs_end(0);
    repeat (20) @(negedge clk);
    check("abort_rx_kept", rx_data[0], 16'h0033);
    tx_load(0, 16'h0096);
    push_exp(0, 16'h00C3);
    cs_start(0);
    xfer(0, 16'h00C3, 8, din);
    cs_end(0);
    wait_drain();
    check("abort_next_miso", din, 16'h0096);
    check("abort_next_rx", rx_data[0], 16'h00C3);

    // Asynchronous reset in the middle of a word
    tx_load(0, 16'h0042);
    cs_start(0);
    xfer(0, 16'h0077, 3, din);
    #(H / 2);
    rst_n = 1'b0;
    #1;
    check_reset_state(0);
    cs_n[0] = 1'b1;
    sclk    = 1'b0;
    #(2 * H);
    rst_n = 1'b1;
    #(2 * H);
    tx_load(0, 16'h0024);
    push_exp(0, 16'h005A);
    cs_start(0);
    xfer(0, 16'h005A, 8, din);
    cs_end(0);
    wait_drain();
    check("post_rst_miso", din, 16'h0024);
    check("post_rst_rx", rx_data[0], 16'h005A);

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
